systim_alarm_sched: RTL and testbench

SYSTIM_ALARM_SCHED -- requirements
Module: systim_alarm_sched

---
 rtl/systim_alarm_sched.sv | 148 ++++++++++++++
 tb/tb_systim_alarm_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/systim_alarm_sched.sv
// systim_alarm_sched: multi-channel usec/msec alarm scheduler with a round-robin expiry event output.
// Build option: define SYSTIM_ALARM_OVERRUN_EN to enable sticky per-channel overrun tracking.
module systim_alarm_sched #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      usec_p,
    input  logic                      msec_p,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic                      cfg_cmd,
    input  logic [CNT_W-1:0]          cfg_period,
    input  logic                      cfg_unit,
    input  logic                      cfg_periodic,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(NUM_CH)-1:0] evt_ch,
    output logic [NUM_CH-1:0]         active,
    output logic [NUM_CH-1:0]         pending,
    output logic [NUM_CH-1:0]         overrun,
    input  logic [NUM_CH-1:0]         overrun_clr
);
    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_t;

    logic [NUM_CH-1:0] expire;
    logic [NUM_CH-1:0] cancel;
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] rot;
    logic [NUM_CH-1:0] gnt_oh;
    logic [CNT_W-1:0]  arm_val;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   gnt_idx;
    logic [CH_W:0]     sum;
    logic              gnt_found;
    logic              load;

    assign cfg_ready = !rst;
    assign arm_val   = (cfg_period == '0) ? CNT_W'(1) : cfg_period;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ch_state_t        state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
        logic             unit_q, unit_d, periodic_q, periodic_d;
        logic             hit, tick;

        assign hit       = cfg_valid && (cfg_ch == CH_W'(c));
        assign tick      = unit_q ? msec_p : usec_p;
        assign cancel[c] = hit && !cfg_cmd;
        assign expire[c] = (state_q == RUN) && tick && (cnt_q == CNT_W'(1)) && !hit;
        assign active[c] = (state_q == RUN);

        // Commands override counting; expiry reloads periodic channels or idles one-shots.
        always_comb begin
            state_d    = state_q;
            cnt_d      = cnt_q;
            period_d   = period_q;
            unit_d     = unit_q;
            periodic_d = periodic_q;
            if (hit && cfg_cmd) begin
                state_d    = RUN;
                cnt_d      = arm_val;
                period_d   = arm_val;
                unit_d     = cfg_unit;
                periodic_d = cfg_periodic;
            end else if (hit) begin
                state_d = IDLE;
            end else if (state_q == RUN && tick) begin
                cnt_d   = (cnt_q == CNT_W'(1)) ? period_q : cnt_q - 1'b1;
                state_d = (cnt_q == CNT_W'(1) && !periodic_q) ? IDLE : RUN;
            end
        end

        // Per-channel state register.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                period_q   <= '0;
                unit_q     <= 1'b0;
                periodic_q <= 1'b0;
            end else begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                period_q   <= period_d;
                unit_q     <= unit_d;
                periodic_q <= periodic_d;
            end
        end
    end

    assign load = !evt_valid || evt_ready;
    assign elig = pending & ~cancel;
    assign rot  = NUM_CH'({elig, elig} >> rr_ptr);

    // Round-robin pick: first eligible channel at or after rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_found = 1'b1;
                sum       = {1'b0, rr_ptr} + (CH_W + 1)'(k);
                gnt_idx   = (sum >= (CH_W + 1)'(NUM_CH)) ? CH_W'(sum - (CH_W + 1)'(NUM_CH)) : CH_W'(sum);
            end
        end
    end

    assign gnt_oh = {{(NUM_CH - 1){1'b0}}, load && gnt_found} << gnt_idx;

    // Output event register; reloads whenever it is empty or being consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            evt_valid <= gnt_found;
            if (gnt_found) begin
                evt_ch <= gnt_idx;
                rr_ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Pending flags: a new expiry always wins over a grant or a cancel clearing the bit.
    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= (pending & ~cancel & ~gnt_oh) | expire;
    end

`ifdef SYSTIM_ALARM_OVERRUN_EN
    // Sticky overrun: expiry while still pending and not granted this cycle; set beats clear.
    always_ff @(posedge clk) begin
        if (rst) overrun <= '0;
        else     overrun <= (overrun & ~overrun_clr) | (expire & pending & ~gnt_oh);
    end
`else
    logic unused_clr;
    assign unused_clr = ^overrun_clr;
    assign overrun    = '0;
`endif
endmodule

// File: tb/tb_systim_alarm_sched.sv
// tb_systim_alarm_sched: randomized and directed scoreboard bench against a behavioural alarm model.
module tb_systim_alarm_sched;
    localparam int N = 4;
    localparam int W = 16;

    logic                 clk = 1'b0;
    logic                 rst, usec_p, msec_p, cfg_valid, cfg_ready, cfg_cmd, cfg_unit, cfg_periodic;
    logic [$clog2(N)-1:0] cfg_ch, evt_ch;
    logic [W-1:0]         cfg_period;
    logic                 evt_valid, evt_ready;
    logic [N-1:0]         active, pending, overrun, overrun_clr;

    int checks = 0;
    int errors = 0;

    int rem [N];
    int per [N];
    bit unt [N];
    bit perd[N];
    bit act [N];
    bit pend[N];
    bit ovr [N];
    bit m_valid = 1'b0;
    int m_ch    = 0;
    int m_start = 0;
    int exp_q[$];

    systim_alarm_sched #(.NUM_CH(N), .CNT_W(W)) dut (
        .clk(clk), .rst(rst), .usec_p(usec_p), .msec_p(msec_p),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_cmd(cfg_cmd),
        .cfg_period(cfg_period), .cfg_unit(cfg_unit), .cfg_periodic(cfg_periodic),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
        .active(active), .pending(pending), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    // One clock of the alarm rules applied to the inputs seen at this edge.
    task automatic model_step();
        bit hit[N];
        bit ex[N];
        bit tk[N];
        int g = -1;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                rem[i] = 0; per[i] = 0; unt[i] = 0; perd[i] = 0; act[i] = 0; pend[i] = 0; ovr[i] = 0;
            end
            m_valid = 0; m_ch = 0; m_start = 0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            hit[i] = cfg_valid && (int'(cfg_ch) == i);
            tk[i]  = unt[i] ? msec_p : usec_p;
            ex[i]  = act[i] && tk[i] && rem[i] == 1 && !hit[i];
        end
        if (!m_valid || evt_ready) begin
            m_valid = 0;
            for (int k = 0; k < N; k++)
                if (g < 0 && pend[(m_start + k) % N] && !(hit[(m_start + k) % N] && !cfg_cmd))
                    g = (m_start + k) % N;
            if (g >= 0) begin
                m_valid = 1; m_ch = g; m_start = (g + 1) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
`ifdef SYSTIM_ALARM_OVERRUN_EN
            ovr[i] = (ex[i] && pend[i] && g != i) ? 1'b1 : overrun_clr[i] ? 1'b0 : ovr[i];
`else
            ovr[i] = 1'b0;
`endif
            pend[i] = ex[i] ? 1'b1 : ((hit[i] && !cfg_cmd) || g == i) ? 1'b0 : pend[i];
            if (hit[i] && cfg_cmd) begin
                per[i] = (cfg_period == 0) ? 1 : int'(cfg_period);
                rem[i] = per[i]; unt[i] = cfg_unit; perd[i] = cfg_periodic; act[i] = 1;
            end else if (hit[i]) begin
                act[i] = 0;
            end else if (act[i] && tk[i]) begin
                if (rem[i] == 1) begin
                    if (perd[i]) rem[i] = per[i];
                    else act[i] = 0;
                end else rem[i]--;
            end
        end
    endtask

    // Model process: advance at each edge, then predict the handshake of the coming edge.
    always begin
        @(posedge clk);
        model_step();
        #3;
        if (m_valid && evt_ready) exp_q.push_back(m_ch);
    end

    // Monitor: compare visible state and pop the scoreboard on every DUT handshake.
    always @(negedge clk) begin
        logic [N-1:0] ea, ep, eo;
        for (int i = 0; i < N; i++) begin
            ea[i] = act[i]; ep[i] = pend[i]; eo[i] = ovr[i];
        end
        chk("cfg_ready", cfg_ready, !rst);
        chk("evt_valid", evt_valid, m_valid);
        if (m_valid) chk("evt_ch", evt_ch, m_ch);
        chk("active", active, ea);
        chk("pending", pending, ep);
        chk("overrun", overrun, eo);
        if (evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_event at %0t: got ch %0d expected none", $time, evt_ch);
            end else chk("sb_evt_ch", evt_ch, exp_q.pop_front());
        end else if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL missed_event at %0t: got none expected ch %0d", $time, exp_q.pop_front());
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
            usec_p = 0; msec_p = 0; cfg_valid = 0; overrun_clr = '0;
        end
    endtask

    task automatic arm(int ch, int p, bit unit, bit periodic);
        cfg_valid = 1; cfg_ch = ch[$clog2(N)-1:0]; cfg_cmd = 1; cfg_period = p[W-1:0];
        cfg_unit = unit; cfg_periodic = periodic;
        step(1);
    endtask

    task automatic cancel(int ch);
        cfg_valid = 1; cfg_ch = ch[$clog2(N)-1:0]; cfg_cmd = 0;
        step(1);
    endtask

    initial begin
        rst = 1; usec_p = 0; msec_p = 0; cfg_valid = 0; cfg_ch = '0; cfg_cmd = 0;
        cfg_period = '0; cfg_unit = 0; cfg_periodic = 0; evt_ready = 0; overrun_clr = '0;
        step(3);
        rst = 0;
        step(1);
        // one-shot usec alarm on ch1
        evt_ready = 1;
        arm(1, 3, 0, 0);
        repeat (3) begin usec_p = 1; step(1); step(2); end
        step(4);
        // periodic msec alarm on ch0, then cancel
        arm(0, 2, 1, 1);
        repeat (6) begin msec_p = 1; usec_p = 1; step(1); step(3); end
        cancel(0);
        repeat (4) begin msec_p = 1; step(1); step(1); end
        // four simultaneous expiries drained in round-robin order after a stall
        evt_ready = 0;
        for (int c = 0; c < N; c++) arm(c, 1, 0, 0);
        usec_p = 1; step(1);
        step(10);
        evt_ready = 1;
        step(8);
        // merged expiries and overrun on ch2
        evt_ready = 0;
        arm(2, 1, 0, 1);
        repeat (3) begin usec_p = 1; step(1); step(1); end
        step(2);
        overrun_clr = 4'b0100; step(1);
        evt_ready = 1; step(4);
        cancel(2); step(3);
        // re-arm on the exact expiry cycle
        arm(3, 2, 0, 0);
        usec_p = 1; step(1); step(1);
        usec_p = 1; arm(3, 5, 0, 0);
        repeat (6) begin usec_p = 1; step(1); step(1); end
        step(3);
        // reset while holding an event with every channel running
        evt_ready = 0;
        for (int c = 0; c < N; c++) arm(c, 2, 0, 1);
        repeat (4) begin usec_p = 1; step(1); end
        step(2);
        rst = 1; step(1);
        rst = 0; evt_ready = 1;
        repeat (100) begin usec_p = 1; msec_p = 1; step(1); end
        // randomized traffic
        repeat (4000) begin
            rst          = ($urandom_range(999) == 0);
            usec_p       = ($urandom_range(2) == 0);
            msec_p       = ($urandom_range(9) == 0);
            cfg_valid    = ($urandom_range(5) == 0);
            cfg_ch       = $urandom_range(N - 1);
            cfg_cmd      = ($urandom_range(3) != 0);
            cfg_period   = $urandom_range(6);
            cfg_unit     = ($urandom_range(4) == 0);
            cfg_periodic = $urandom_range(1);
            evt_ready    = ($urandom_range(3) != 0);
            overrun_clr  = ($urandom_range(7) == 0) ? N'($urandom) : '0;
            step(1);
        end
        rst = 0; evt_ready = 1;
        step(5);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
